// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the serial XOR cipher path.
// State encoding, default widths and key replication.
package xor_cipher_pkg;

    localparam int DEF_KEY_SIZE = 4;
    localparam int DEF_MSG_SIZE = 8;
    localparam int REP_MAX      = 64;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_KEY = 3'd1;
    localparam logic [2:0] LOAD_CT  = 3'd2;
    localparam logic [2:0] DECRYPT  = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    // Message bit i takes key bit (i mod keySize), so key MSB meets message MSB.
    function automatic logic [REP_MAX-1:0] replicateKey(
        input logic [REP_MAX-1:0] key,
        input int                 keySize
    );
        logic [REP_MAX-1:0] rep;
        rep = '0;
        for (int i = 0; i < REP_MAX; i++) begin
            rep[i] = key[i % keySize];
        end
        return rep;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out register, MSB first.
// Shifts left on enable; asynchronous active-high clear.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iClr,
    input  logic             iEn,
    input  logic             iData,
    output logic [WIDTH-1:0] oQ
);

    generate
        if (WIDTH > 1) begin : gWide
            always_ff @(posedge iClk or posedge iClr) begin
                if (iClr) begin
                    oQ <= '0;
                end else if (iEn) begin
                    oQ <= {oQ[WIDTH-2:0], iData};
                end
            end
        end else begin : gBit
            always_ff @(posedge iClk or posedge iClr) begin
                if (iClr) begin
                    oQ <= '0;
                end else if (iEn) begin
                    oQ <= iData;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/xor_decrypt_core.sv
// Serial XOR decryptor: loads key and ciphertext bit-serially,
// returns plaintext MSB-first on the same single-pin protocol.
module xor_decrypt_core
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE = DEF_KEY_SIZE,
    parameter int MSG_SIZE = DEF_MSG_SIZE
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iData_in,
    input  logic iLoad_key,
    input  logic iLoad_ct,
    output logic oData_out,
    output logic oValid,
    output logic oDone_flag,
    output logic oKey_valid,
    output logic oBusy
);

    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] CT_LAST  = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] MSG_END  = CW'(MSG_SIZE);

    logic [2:0]          state;
    logic [2:0]          stateNxt;
    logic [CW-1:0]       bitCnt;
    logic [KEY_SIZE-1:0] keyReg;
    logic [MSG_SIZE-1:0] ctReg;
    logic [MSG_SIZE-1:0] ptReg;
    logic [MSG_SIZE-1:0] keyRep;
    logic                keyStart;
    logic                ctStart;
    logic                keyShift;
    logic                ctShift;
    logic                keyLast;
    logic                ctLast;

    assign keyStart = iEn && (state == IDLE) && iLoad_key;
    assign ctStart  = iEn && (state == IDLE) && !iLoad_key
                      && iLoad_ct && oKey_valid;
    assign keyShift = keyStart || (iEn && (state == LOAD_KEY));
    assign ctShift  = ctStart || (iEn && (state == LOAD_CT));
    assign keyLast  = (bitCnt == KEY_LAST);
    assign ctLast   = (bitCnt == CT_LAST);
    assign keyRep   = MSG_SIZE'(replicateKey(REP_MAX'(keyReg), KEY_SIZE));

    sipo_shift_reg #(.WIDTH(KEY_SIZE)) uKeySr (
        .iClk  (iClk),
        .iClr  (iRst),
        .iEn   (keyShift),
        .iData (iData_in),
        .oQ    (keyReg)
    );

    sipo_shift_reg #(.WIDTH(MSG_SIZE)) uCtSr (
        .iClk  (iClk),
        .iClr  (iRst),
        .iEn   (ctShift),
        .iData (iData_in),
        .oQ    (ctReg)
    );

    always_comb begin
        stateNxt = state;
        if (iEn) begin
            unique case (state)
                IDLE: begin
                    if (iLoad_key) begin
                        stateNxt = LOAD_KEY;
                    end else if (iLoad_ct && oKey_valid) begin
                        stateNxt = LOAD_CT;
                    end
                end
                LOAD_KEY: if (keyLast) stateNxt = IDLE;
                LOAD_CT:  if (ctLast) stateNxt = DECRYPT;
                DECRYPT:  stateNxt = SEND;
                SEND:     if (bitCnt == MSG_END) stateNxt = DONE;
                DONE:     stateNxt = IDLE;
                default:  stateNxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= IDLE;
            bitCnt     <= '0;
            ptReg      <= '0;
            oData_out  <= 1'b0;
            oValid     <= 1'b0;
            oDone_flag <= 1'b0;
            oKey_valid <= 1'b0;
            oBusy      <= 1'b0;
        end else if (iEn) begin
            state      <= stateNxt;
            oBusy      <= (stateNxt != IDLE);
            oDone_flag <= (stateNxt == DONE);
            unique case (state)
                IDLE: begin
                    // The start-cycle bit is already the MSB, so count from 1.
                    if (keyStart || ctStart) bitCnt <= CW'(1);
                    if (keyStart) oKey_valid <= 1'b0;
                end
                LOAD_KEY: begin
                    bitCnt <= bitCnt + 1'b1;
                    if (keyLast) oKey_valid <= 1'b1;
                end
                LOAD_CT: begin
                    bitCnt <= bitCnt + 1'b1;
                end
                DECRYPT: begin
                    ptReg  <= ctReg ^ keyRep;
                    bitCnt <= '0;
                end
                SEND: begin
                    if (bitCnt == MSG_END) begin
                        oValid    <= 1'b0;
                        oData_out <= 1'b0;
                    end else begin
                        oValid    <= 1'b1;
                        oData_out <= ptReg[MSG_SIZE-1];
                        ptReg     <= ptReg << 1;
                        bitCnt    <= bitCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_decrypt_core.sv
// Directed bench for xor_decrypt_core with KEY_SIZE=4, MSG_SIZE=8.
// Hand-computed plaintexts, stalls, async reset and key retention.
module tb_xor_decrypt_core;

    logic iClk;
    logic iRst;
    logic iEn;
    logic iData_in;
    logic iLoad_key;
    logic iLoad_ct;
    logic oData_out;
    logic oValid;
    logic oDone_flag;
    logic oKey_valid;
    logic oBusy;

    int checks = 0;
    int errors = 0;

    xor_decrypt_core #(.KEY_SIZE(4), .MSG_SIZE(8)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iData_in   (iData_in),
        .iLoad_key  (iLoad_key),
        .iLoad_ct   (iLoad_ct),
        .oData_out  (oData_out),
        .oValid     (oValid),
        .oDone_flag (oDone_flag),
        .oKey_valid (oKey_valid),
        .oBusy      (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic loadKey(input logic [3:0] k, input logic both);
        iLoad_key = 1'b1;
        iLoad_ct  = both;
        for (int i = 3; i >= 0; i--) begin
            iData_in = k[i];
            step();
            iLoad_key = 1'b0;
            iLoad_ct  = 1'b0;
            if (i > 0) begin
                chk("key_busy", 8'(oBusy), 8'd1);
                chk("key_valid_low", 8'(oKey_valid), 8'd0);
            end
        end
        chk("key_valid", 8'(oKey_valid), 8'd1);
        chk("key_idle", 8'(oBusy), 8'd0);
    endtask

    task automatic sendCt(input logic [7:0] ct, input int stallAt);
        iLoad_ct = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == stallAt) begin
                iEn      = 1'b0;
                iData_in = ~ct[i];
                repeat (3) begin
                    step();
                    chk("ct_stall_busy", 8'(oBusy), 8'd1);
                end
                iEn = 1'b1;
            end
            iData_in = ct[i];
            step();
            iLoad_ct = 1'b0;
        end
        chk("ct_loaded_busy", 8'(oBusy), 8'd1);
        chk("ct_loaded_valid", 8'(oValid), 8'd0);
    endtask

    task automatic runSend(input logic [7:0] exp, input int stallAt);
        logic [7:0] got;
        got = '0;
        step();
        chk("decrypt_valid", 8'(oValid), 8'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("send_valid", 8'(oValid), 8'd1);
            got = {got[6:0], oData_out};
            if (i == stallAt) begin
                iEn = 1'b0;
                repeat (3) begin
                    step();
                    chk("stall_valid", 8'(oValid), 8'd1);
                    chk("stall_bit", 8'(oData_out), 8'(got[0]));
                end
                iEn = 1'b1;
            end
        end
        chk("plaintext", got, exp);
        step();
        chk("done_pulse", 8'(oDone_flag), 8'd1);
        chk("done_valid", 8'(oValid), 8'd0);
        step();
        chk("done_clear", 8'(oDone_flag), 8'd0);
        chk("back_idle", 8'(oBusy), 8'd0);
    endtask

    initial begin
        iRst      = 1'b1;
        iEn       = 1'b1;
        iData_in  = 1'b0;
        iLoad_key = 1'b0;
        iLoad_ct  = 1'b0;
        step();
        step();
        chk("reset_outs",
            8'({oData_out, oValid, oDone_flag, oKey_valid, oBusy}), 8'd0);
        iRst = 1'b0;
        step();

        // Ciphertext strobe without a key is ignored.
        iLoad_ct = 1'b1;
        iData_in = 1'b1;
        step();
        iLoad_ct = 1'b0;
        chk("nokey_busy", 8'(oBusy), 8'd0);
        repeat (4) begin
            step();
            chk("nokey_valid", 8'(oValid), 8'd0);
        end

        // Key 1010, ct 01101100 -> 11000110.
        loadKey(4'b1010, 1'b0);
        sendCt(8'b01101100, -1);
        runSend(8'b11000110, -1);

        // Round trip: 0xA5 ^ 0x33 = 0x96.
        loadKey(4'h3, 1'b0);
        sendCt(8'h96, -1);
        runSend(8'hA5, -1);

        // Both strobes with a valid key: key load must win.
        loadKey(4'b1010, 1'b1);
        sendCt(8'h3C, 4);
        runSend(8'h96, 3);

        // Back-to-back messages on one key.
        loadKey(4'h5, 1'b0);
        sendCt(8'h00, -1);
        runSend(8'h55, -1);
        sendCt(8'hFF, -1);
        runSend(8'hAA, -1);

        // Asynchronous reset mid-send.
        sendCt(8'h0F, -1);
        repeat (4) step();
        chk("pre_reset_valid", 8'(oValid), 8'd1);
        #2;
        iRst = 1'b1;
        #1;
        chk("async_reset_outs",
            8'({oData_out, oValid, oDone_flag, oKey_valid, oBusy}), 8'd0);
        step();
        iRst = 1'b0;
        iLoad_ct = 1'b1;
        step();
        iLoad_ct = 1'b0;
        chk("post_reset_ct_busy", 8'(oBusy), 8'd0);
        chk("post_reset_key", 8'(oKey_valid), 8'd0);
        repeat (10) begin
            step();
            chk("post_reset_valid", 8'(oValid), 8'd0);
        end

        loadKey(4'h5, 1'b0);
        sendCt(8'h0F, -1);
        runSend(8'h5A, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
